// File: rtl/tick_timer_if.sv
// tick_timer_if: control, period-load and status signals between a controller and tick_timer
interface tick_timer_if #(parameter int CNT_W = 16);
  logic cntr_reset, enable, oneshot, period_load, period_ack, tick;
  logic [CNT_W-1:0] period_in, count;
  logic [1:0] state;
  modport master (output cntr_reset, enable, oneshot, period_in, period_load,
                  input period_ack, tick, count, state);
  modport slave (input cntr_reset, enable, oneshot, period_in, period_load,
                 output period_ack, tick, count, state);
endinterface

// File: rtl/tick_timer.sv
// tick_timer: prescaled strobe counter emitting periodic or one-shot ticks with a shadowed period
module tick_timer #(
  parameter int PRESCALE       = 4,
  parameter int CNT_W          = 16,
  parameter int DEFAULT_PERIOD = 3
) (
  input logic         clk,
  input logic         res,
  tick_timer_if.slave bus
);
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, DONE = 2'b10} state_e;
  state_e state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, per_q, per_d, sh_q, sh_d, ld_val;
  logic sh_v_q, sh_v_d, tick_q, tick_d, ack_q;
  logic cnt_en, strobe, wrap, commit;
  assign ld_val = (bus.period_in == '0) ? CNT_W'(1) : bus.period_in;
  always_comb begin
    cnt_en  = state_q == RUN && bus.enable;
    strobe  = cnt_en && pre_q == PW'(PRESCALE - 1);
    wrap    = strobe && cnt_q == per_q - CNT_W'(1);
    sh_d    = bus.period_load ? ld_val : sh_q;
    // a load arriving with the commit event is taken immediately rather than left pending
    commit  = (bus.period_load || sh_v_q) && (bus.cntr_reset || wrap);
    sh_v_d  = (bus.period_load || sh_v_q) && !commit;
    per_d   = commit ? sh_d : per_q;
    pre_d   = (bus.cntr_reset || strobe) ? '0 : cnt_en ? pre_q + PW'(1) : pre_q;
    cnt_d   = (bus.cntr_reset || wrap) ? '0 : strobe ? cnt_q + CNT_W'(1) : cnt_q;
    tick_d  = wrap && !bus.cntr_reset;
    state_d = bus.cntr_reset ? IDLE :
              (state_q == IDLE && bus.enable) ? RUN :
              (state_q == RUN && wrap && bus.oneshot) ? DONE : state_q;
  end
  always_ff @(posedge clk) begin
    if (!res) begin
      state_q <= IDLE;
      pre_q   <= '0;
      cnt_q   <= '0;
      per_q   <= CNT_W'(DEFAULT_PERIOD);
      sh_q    <= '0;
      sh_v_q  <= 1'b0;
      tick_q  <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      cnt_q   <= cnt_d;
      per_q   <= per_d;
      sh_q    <= sh_d;
      sh_v_q  <= sh_v_d;
      tick_q  <= tick_d;
      ack_q   <= bus.period_load;
    end
  end
  assign bus.tick       = tick_q;
  assign bus.period_ack = ack_q;
  assign bus.count      = cnt_q;
  assign bus.state      = state_q;
endmodule

// File: tb/tb_tick_timer.sv
// tb_tick_timer: directed checks of tick_timer with PRESCALE=4, DEFAULT_PERIOD=3
module tb_tick_timer;
  logic clk = 1'b0, res = 1'b0;
  int n_cmp = 0, n_bad = 0, cyc = 0;
  tick_timer_if #(.CNT_W(16)) bus();
  tick_timer #(.PRESCALE(4), .CNT_W(16), .DEFAULT_PERIOD(3)) dut (.clk(clk), .res(res), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask
  // cyc 0 is the first edge with res high; ticks expected at first, first+per, ...
  task automatic run_ticks(input int upto, input int first, input int per);
    while (cyc < upto) begin
      step();
      chk($sformatf("tick@%0d", cyc), 32'(bus.tick), 32'(cyc >= first && (cyc - first) % per == 0));
    end
  endtask
  task automatic start(input logic os);
    res = 1'b0;
    bus.cntr_reset = 1'b0;
    bus.enable = 1'b1;
    bus.oneshot = os;
    bus.period_load = 1'b0;
    bus.period_in = '0;
    step();
    step();
    res = 1'b1;
    cyc = -1;
  endtask
  initial begin
    bus.cntr_reset = 1'b0;
    bus.enable = 1'b0;
    bus.oneshot = 1'b0;
    bus.period_load = 1'b1;
    bus.period_in = 16'd7;
    step();
    step();
    chk("rst_tick", 32'(bus.tick), 0);
    chk("rst_ack", 32'(bus.period_ack), 0);
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_state", 32'(bus.state), 0);
    bus.period_load = 1'b0;
    res = 1'b1;
    step();
    step();
    chk("idle_hold", 32'(bus.state), 0);
    // periodic with defaults
    start(1'b0);
    run_ticks(36, 12, 12);
    chk("per_state", 32'(bus.state), 1);
    chk("per_count", 32'(bus.count), 0);
    // one-shot, DONE hold, restart
    start(1'b1);
    run_ticks(12, 12, 1000);
    chk("os_done", 32'(bus.state), 2);
    run_ticks(112, 100000, 1);
    chk("os_cnt0", 32'(bus.count), 0);
    bus.cntr_reset = 1'b1;
    step();
    bus.cntr_reset = 1'b0;
    chk("os_idle", 32'(bus.state), 0);
    cyc = -1;
    run_ticks(12, 12, 1000);
    chk("os_done2", 32'(bus.state), 2);
    // period change at count=1
    start(1'b0);
    run_ticks(4, 12, 20);
    chk("ld_cnt1", 32'(bus.count), 1);
    bus.period_load = 1'b1;
    bus.period_in = 16'd5;
    step();
    bus.period_load = 1'b0;
    chk("ld_ack", 32'(bus.period_ack), 1);
    step();
    chk("ld_ack_off", 32'(bus.period_ack), 0);
    run_ticks(52, 12, 20);
    // cntr_reset on the tick edge
    start(1'b0);
    run_ticks(11, 12, 12);
    bus.cntr_reset = 1'b1;
    step();
    bus.cntr_reset = 1'b0;
    chk("cr_tick", 32'(bus.tick), 0);
    chk("cr_count", 32'(bus.count), 0);
    chk("cr_state", 32'(bus.state), 0);
    cyc = -1;
    run_ticks(24, 12, 12);
    // zero period stored as one
    start(1'b0);
    run_ticks(1, 12, 4);
    bus.period_load = 1'b1;
    bus.period_in = 16'd0;
    step();
    bus.period_load = 1'b0;
    chk("z_ack", 32'(bus.period_ack), 1);
    run_ticks(24, 12, 4);
    // res mid-period discards pending shadow
    start(1'b0);
    run_ticks(5, 12, 12);
    bus.period_load = 1'b1;
    bus.period_in = 16'd5;
    step();
    bus.period_load = 1'b0;
    run_ticks(8, 12, 12);
    chk("rs_cnt2", 32'(bus.count), 2);
    res = 1'b0;
    step();
    res = 1'b1;
    chk("rs_count", 32'(bus.count), 0);
    chk("rs_state", 32'(bus.state), 0);
    chk("rs_tick", 32'(bus.tick), 0);
    cyc = -1;
    run_ticks(24, 12, 12);
    // enable low freezes progress
    start(1'b0);
    run_ticks(6, 12, 12);
    bus.enable = 1'b0;
    run_ticks(11, 100000, 1);
    chk("frz_count", 32'(bus.count), 1);
    bus.enable = 1'b1;
    run_ticks(29, 17, 12);
    // load together with cntr_reset commits immediately
    start(1'b0);
    run_ticks(5, 12, 12);
    bus.cntr_reset = 1'b1;
    bus.period_load = 1'b1;
    bus.period_in = 16'd2;
    step();
    bus.cntr_reset = 1'b0;
    bus.period_load = 1'b0;
    chk("crl_ack", 32'(bus.period_ack), 1);
    cyc = -1;
    run_ticks(24, 8, 8);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/tick_timer.md
TICK_TIMER -- requirements
Module: tick_timer

Interface
REQ-001: Parameter PRESCALE, default 4, is clk cycles per base strobe (>=1).
REQ-002: Parameter CNT_W, default 16, is the width of the period and count.
REQ-003: Parameter DEFAULT_PERIOD, default 3, is the active period loaded at reset, in strobes.
REQ-004: clk  in  1  sole clock; all state changes on rising edge.
REQ-005: res  in  1  synchronous, active-low reset.
REQ-006: cntr_reset  in  1  restart request from the consuming controller.
REQ-007: enable  in  1  counting permitted when high.
REQ-008: oneshot  in  1  1 = stop after first tick, 0 = periodic.
REQ-009: period_in  in  CNT_W  new period value.
REQ-010: period_load  in  1  one-cycle request to stage period_in.
REQ-011: period_ack  out  1  one-cycle acknowledge of period_load.
REQ-012: tick  out  1  one-cycle expiry pulse.
REQ-013: count  out  CNT_W  current strobe count.
REQ-014: state  out  2  00 IDLE, 01 RUN, 10 DONE.

Function
REQ-015: Prescaler counts 0..PRESCALE-1 only in RUN with enable=1; strobe is true in the cycle it equals PRESCALE-1, and the prescaler then wraps to 0.
REQ-016: On strobe, count increments; if count == active_period-1, count wraps to 0 and tick is registered high for exactly the next cycle.
REQ-017: Tick latency is active_period*PRESCALE clk cycles from leaving reset/cntr_reset with enable held high.
REQ-018: enable=0 freezes the prescaler and count without clearing them; no tick is produced.
REQ-019: State IDLE -> RUN when enable=1; RUN -> DONE on the tick edge when oneshot=1; RUN stays in RUN when oneshot=0.
REQ-020: In DONE, the prescaler and count hold at 0 and no further tick occurs.
REQ-021: cntr_reset=1 clears the prescaler and count to 0, suppresses any tick from that cycle, and moves DONE/RUN -> IDLE.
REQ-022: cntr_reset has priority over strobe, period_load commit and enable in the same cycle.
REQ-023: period_load stages period_in in a shadow register; period_ack is high the following cycle, one pulse per request.
REQ-024: The shadow register transfers to active_period only at a count wrap or at cntr_reset, never mid-period.
REQ-025: A loaded value of 0 is stored as 1.
REQ-026: A period_load while a shadow value is pending overwrites it (last wins) and is still acknowledged.
REQ-027: period_load in the same cycle as cntr_reset is staged and committed by that cntr_reset.
REQ-028: count is always < active_period; all arithmetic is unsigned, CNT_W bits.

Reset
REQ-029: When res=0 at a clk edge, outputs and state are: tick=0, period_ack=0, count=0, prescaler=0, state=IDLE, active_period=DEFAULT_PERIOD, shadow empty.
REQ-030: res=0 has priority over every other input, including mid-period and in DONE.
REQ-031: After release, the first strobe occurs no earlier than PRESCALE cycles after the first RUN cycle.

Verification
REQ-032: Defaults, enable=1, oneshot=0 -> tick pulses at cycles 12, 24, 36 after reset release, each 1 cycle wide.
REQ-033: oneshot=1 -> exactly one tick at cycle 12; state=10; no tick for 100 further cycles; cntr_reset -> IDLE, then a tick 12 cycles after counting resumes.
REQ-034: At count=1, period_load with period_in=5 -> period_ack next cycle; the current period ends at 3 strobes; the following period is 20 cycles.
REQ-035: cntr_reset asserted on the cycle where a tick would fire -> no tick; count=0; the next tick comes a full 12 cycles after counting resumes.
REQ-036: period_in=0 loaded -> tick every 4 cycles after the next wrap.
REQ-037: res=0 mid-period at count=2 -> count=0, state=00, tick=0 next cycle; shadow value discarded.
